// File: rtl/dct_pkg.sv
// Shared DCT definitions: sequencer state encoding, block geometry and the default
// datapath widths also used by the cosine LUT bank and the coefficient writer.
package dct_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_ADDR_W = 6;
  localparam int DCT_IDX_W  = 3;

  localparam int DCT_PIX_W  = 8;
  localparam int DCT_COS_W  = 32;
  localparam int DCT_ACC_W  = 48;
  localparam int DCT_SHIFT  = 10;
  localparam int DCT_OUT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LAST,
    ST_ROUND,
    ST_OUT
  } dct_seq_state_t;

endpackage

// File: rtl/dct_mac.sv
// Registered multiply-accumulate: acc += pixel * cos_term while enabled; clear has priority.
module dct_mac
  import dct_pkg::*;
#(
  parameter int PIX_W = DCT_PIX_W,
  parameter int COS_W = DCT_COS_W,
  parameter int ACC_W = DCT_ACC_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic signed [PIX_W:0]   pixel,
  input  logic signed [COS_W-1:0] cos_term,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PROD_W = PIX_W + 1 + COS_W;

  logic signed [PROD_W-1:0] prod;

  assign prod = pixel * cos_term;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/dct_coeff_sequencer.sv
// Sequences one 8x8 2-D DCT coefficient: 64 pixel reads, MAC against the cosine LUT,
// round/saturate, valid/ready output. `DCT_LEVEL_SHIFT_EN subtracts 2^(PIX_W-1) per pixel.
module dct_coeff_sequencer
  import dct_pkg::*;
#(
  parameter int PIX_W = DCT_PIX_W,
  parameter int COS_W = DCT_COS_W,
  parameter int ACC_W = DCT_ACC_W,
  parameter int SHIFT = DCT_SHIFT,
  parameter int OUT_W = DCT_OUT_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       start_ready,
  input  logic [DCT_IDX_W-1:0]       k1,
  input  logic [DCT_IDX_W-1:0]       k2,
  output logic [DCT_IDX_W-1:0]       lut_k1,
  output logic [DCT_IDX_W-1:0]       lut_k2,
  output logic [DCT_IDX_W-1:0]       lut_n1,
  output logic [DCT_IDX_W-1:0]       lut_n2,
  input  logic signed [COS_W-1:0]    cos_term,
  output logic                       pix_rd_en,
  output logic [DCT_ADDR_W-1:0]      pix_addr,
  input  logic [PIX_W-1:0]           pix_data,
  output logic signed [OUT_W-1:0]    coeff,
  output logic [DCT_IDX_W-1:0]       coeff_k1,
  output logic [DCT_IDX_W-1:0]       coeff_k2,
  output logic                       coeff_valid,
  input  logic                       coeff_ready
);

  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OMAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  dct_seq_state_t state, state_nx;

  logic [DCT_ADDR_W-1:0]   cnt;
  logic                    beat;
  logic                    accept;
  logic signed [PIX_W:0]   pix_s;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rsum;
  logic signed [ACC_W-1:0] rnd;
  logic signed [OUT_W-1:0] sat;

  assign start_ready = (state == ST_IDLE);
  assign accept      = start && start_ready;
  assign pix_rd_en   = (state == ST_READ);
  assign pix_addr    = pix_rd_en ? cnt : '0;
  assign coeff_valid = (state == ST_OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_READ;
      ST_READ:  if (cnt == '1) state_nx = ST_LAST;
      ST_LAST:  state_nx = ST_ROUND;
      ST_ROUND: state_nx = ST_OUT;
      ST_OUT:   if (coeff_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // lut_n* trails pix_addr by one cycle so the LUT output lines up with pix_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      beat     <= 1'b0;
      lut_k1   <= '0;
      lut_k2   <= '0;
      lut_n1   <= '0;
      lut_n2   <= '0;
      coeff_k1 <= '0;
      coeff_k2 <= '0;
      coeff    <= '0;
    end else begin
      beat <= pix_rd_en;
      if (accept) begin
        cnt      <= '0;
        lut_k1   <= k1;
        lut_k2   <= k2;
        coeff_k1 <= k1;
        coeff_k2 <= k2;
      end else if (pix_rd_en) begin
        cnt <= cnt + 6'd1;
      end
      if (pix_rd_en) begin
        {lut_n1, lut_n2} <= pix_addr;
      end
      if (state == ST_ROUND) begin
        coeff <= sat;
      end
    end
  end

`ifdef DCT_LEVEL_SHIFT_EN
  localparam logic signed [PIX_W:0] LEVEL = {2'b01, {(PIX_W-1){1'b0}}};
  assign pix_s = $signed({1'b0, pix_data}) - LEVEL;
`else
  assign pix_s = $signed({1'b0, pix_data});
`endif

  dct_mac #(
    .PIX_W (PIX_W),
    .COS_W (COS_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (beat),
    .pixel    (pix_s),
    .cos_term (cos_term),
    .acc      (acc)
  );

  always_comb begin
    rsum = acc + HALF;
    rnd  = rsum >>> SHIFT;
    if (rnd > OMAX) begin
      sat = OMAX[OUT_W-1:0];
    end else if (rnd < OMIN) begin
      sat = OMIN[OUT_W-1:0];
    end else begin
      sat = rnd[OUT_W-1:0];
    end
  end

endmodule
